datagram_receiver: RTL

- Front end of each quadrant display board. Receives the core's broadcast game-state datagram over a 4-bit strobed inter-board link and verifies its checksum.
- Double-buffers the result and updates the datagram presented to the VGA output stage only at vertical sync, so a displayed frame never mixes two game states.
- Flags a stale or broken link to the downstream stage.

---
 rtl/datagram_receiver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/datagram_receiver.sv
// Quadrant-board link receiver: reassembles nibble-strobed game-state datagrams,
// verifies their checksum and double-buffers them so the display only swaps at vsync.
module datagram_receiver #(
   parameter int MSG_BITS     = 512,
   parameter int STALE_FRAMES = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                link_strobe,
   input  logic                link_sof,
   input  logic [3:0]          link_data,
   input  logic                vsync,
   output logic [MSG_BITS-1:0] datagram,
   output logic                frame_commit,
   output logic                chk_err,
   output logic                stale
);

   localparam int NIBS = MSG_BITS / 4;
   localparam int CW   = $clog2(NIBS + 1);
   localparam int SW   = $clog2(STALE_FRAMES + 1);

   typedef enum logic [1:0] {IDLE, PAYLOAD, CHK_HI, CHK_LO} state_t;

   logic [1:0]          strb_sync, sof_sync, vs_sync;
   logic [3:0]          data_s1, data_s2;
   logic                strb_d, vs_d;
   logic                nib_evt, commit_pt;
   logic [3:0]          nib;

   state_t              state;
   logic [CW-1:0]       nib_cnt;
   logic [7:0]          sum;
   logic [3:0]          chk_hi;
   logic [MSG_BITS-1:0] shadow, hold;
   logic                pending;
   logic [SW-1:0]       stale_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         strb_sync <= '0;
         sof_sync  <= '0;
         vs_sync   <= '0;
         data_s1   <= '0;
         data_s2   <= '0;
         strb_d    <= 1'b0;
         vs_d      <= 1'b0;
      end else begin
         strb_sync <= {strb_sync[0], link_strobe};
         sof_sync  <= {sof_sync[0], link_sof};
         vs_sync   <= {vs_sync[0], vsync};
         data_s1   <= link_data;
         data_s2   <= data_s1;
         strb_d    <= strb_sync[1];
         vs_d      <= vs_sync[1];
      end
   end

   // Data and sof share the strobe's synchroniser depth, so they line up with the event.
   assign nib_evt   = strb_sync[1] ^ strb_d;
   assign commit_pt = vs_d & ~vs_sync[1];
   assign nib       = data_s2;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= IDLE;
         nib_cnt      <= '0;
         sum          <= '0;
         chk_hi       <= '0;
         shadow       <= '0;
         hold         <= '0;
         pending      <= 1'b0;
         datagram     <= '0;
         frame_commit <= 1'b0;
         chk_err      <= 1'b0;
         stale_cnt    <= SW'(STALE_FRAMES);
         stale        <= 1'b1;
      end else begin
         frame_commit <= 1'b0;
         chk_err      <= 1'b0;

         // Commit sees pending from before this cycle; a completion below re-arms it.
         if (commit_pt) begin
            if (pending) begin
               datagram     <= hold;
               pending      <= 1'b0;
               frame_commit <= 1'b1;
               stale_cnt    <= '0;
               stale        <= 1'b0;
            end else if (stale_cnt != SW'(STALE_FRAMES)) begin
               stale_cnt <= stale_cnt + SW'(1);
               stale     <= (stale_cnt + SW'(1) == SW'(STALE_FRAMES));
            end
         end

         if (nib_evt) begin
            if (sof_sync[1]) begin
               shadow[3:0] <= nib;
               nib_cnt     <= CW'(1);
               sum         <= {4'h0, nib};
               state       <= PAYLOAD;
            end else begin
               case (state)
                  PAYLOAD: begin
                     for (int i = 0; i < NIBS; i++)
                        if (nib_cnt == CW'(i)) shadow[i*4 +: 4] <= nib;
                     sum     <= sum + {4'h0, nib};
                     nib_cnt <= nib_cnt + CW'(1);
                     if (nib_cnt == CW'(NIBS - 1)) state <= CHK_HI;
                  end
                  CHK_HI: begin
                     chk_hi <= nib;
                     state  <= CHK_LO;
                  end
                  CHK_LO: begin
                     if ({chk_hi, nib} == sum) begin
                        hold    <= shadow;
                        pending <= 1'b1;
                     end else begin
                        chk_err <= 1'b1;
                     end
                     state <= IDLE;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

endmodule
